// File: rtl/debug_scan_ctrl_pkg.sv
// Shared definitions for the debug-port scan initiator and its output stage.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package debug_scan_ctrl_pkg;

   localparam int DEBUG_DATA_W = 32;

   // Scan FSM state codes.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_SEND  = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_ISSUE = S_ISSUE,
      ST_WAIT  = S_WAIT,
      ST_SEND  = S_SEND,
      ST_FIN   = S_FIN
   } state_t;

   // Debug address map as seen by the dumper.
   localparam int MAP_REG_BASE  = 0;
   localparam int MAP_REG_LAST  = 31;
   localparam int MAP_RS_BASE   = 32;
   localparam int MAP_RS_LAST   = 63;
   localparam int MAP_DMEM_BASE = 64;
   localparam int MAP_DMEM_LAST = 127;

   typedef enum logic [1:0] {
      RGN_REG  = 2'd0,
      RGN_RS   = 2'd1,
      RGN_DMEM = 2'd2,
      RGN_NONE = 2'd3
   } map_region_t;

   // Classify a debug address so the dumper can label each word.
   function automatic map_region_t map_region(input int unsigned a);
      if (a <= MAP_REG_LAST)                        return RGN_REG;
      if (a >= MAP_RS_BASE && a <= MAP_RS_LAST)     return RGN_RS;
      if (a >= MAP_DMEM_BASE && a <= MAP_DMEM_LAST) return RGN_DMEM;
      return RGN_NONE;
   endfunction

endpackage

// File: rtl/debug_scan_ctrl_out_reg.sv
// One-entry valid/ready holding register for a captured debug word (data, addr, last).
// Latency: load appears on the outputs the next cycle.
// Backpressure: contents held stable while m_valid && !m_ready; a load takes priority over an accept.
module debug_out_reg #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_W-1:0]     load_data,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic                  load_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_W-1:0]     m_data,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic                  m_last
);

   // Hold one word until the sink accepts it; payload stays put after acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_addr  <= '0;
         m_last  <= 1'b0;
      end else if (load) begin
         m_valid <= 1'b1;
         m_data  <= load_data;
         m_addr  <= load_addr;
         m_last  <= load_last;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/debug_scan_ctrl.sv
// Debug-port scan initiator: halts the core, reads every debug address in order and streams the words out.
// Latency: per word 1 issue cycle + READ_LAT wait cycles + at least 1 send cycle; done pulses the cycle after the last accept.
// Backpressure: m_ready low freezes the scan on the current word; nothing is skipped or repeated.
module debug_scan_ctrl
   import debug_scan_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int NUM_WORDS  = 128,
   parameter int READ_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    hold,
   input  logic                    step_req,
   output logic                    debug_en,
   output logic                    debug_step,
   output logic [ADDR_WIDTH-1:0]   debug_addr,
   input  logic [DEBUG_DATA_W-1:0] debug_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DEBUG_DATA_W-1:0] m_data,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done
);

   localparam int                    WCNT_W    = $clog2(READ_LAT) + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
   localparam logic [WCNT_W-1:0]     WCNT_INIT = WCNT_W'(READ_LAT - 1);

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WCNT_W-1:0]     wcnt;
   logic                  capture;
   logic                  at_last;
   logic                  xfer;

   assign capture = (state == ST_WAIT) && (wcnt == '0);
   assign at_last = (addr == LAST_ADDR);
   assign xfer    = m_valid && m_ready;

   // Scan sequencer; every port it drives is registered and set on entry to the state that owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         addr       <= '0;
         wcnt       <= '0;
         debug_en   <= 1'b0;
         debug_step <= 1'b0;
         debug_addr <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         debug_step <= 1'b0;
         done       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  // start beats a simultaneous step_req
                  state      <= ST_ISSUE;
                  addr       <= '0;
                  debug_addr <= '0;
                  debug_en   <= 1'b1;
                  busy       <= 1'b1;
               end else begin
                  debug_en <= hold;
                  busy     <= 1'b0;
                  if (step_req && hold) debug_step <= 1'b1;
               end
            end
            ST_ISSUE: begin
               wcnt  <= WCNT_INIT;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wcnt == '0) state <= ST_SEND;
               else            wcnt  <= wcnt - 1'b1;
            end
            ST_SEND: begin
               if (xfer) begin
                  if (at_last) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end else begin
                     addr       <= addr + 1'b1;
                     debug_addr <= addr + 1'b1;
                     state      <= ST_ISSUE;
                  end
               end
            end
            ST_FIN: begin
               state    <= ST_IDLE;
               busy     <= 1'b0;
               debug_en <= hold;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   debug_out_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_W     (DEBUG_DATA_W)
   ) u_out (
      .clk       (clk),
      .rst       (rst),
      .load      (capture),
      .load_data (debug_data),
      .load_addr (addr),
      .load_last (at_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_addr    (m_addr),
      .m_last    (m_last)
   );

endmodule

// File: tb/tb_debug_scan_ctrl.sv
// Directed bench for debug_scan_ctrl: full scans, backpressure, stepping, abort and single-word scan.
// Latency: n/a.
// Backpressure: the bench drives m_ready to stall selected words.
module tb_debug_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // dut1: READ_LAT=1, 128 words
   logic        start1 = 0, hold1 = 0, step1 = 0, rdy1 = 1;
   logic        en1, stp1, v1, ml1, busy1, done1;
   logic [6:0]  addr1, ma1;
   logic [31:0] data1 = '0, md1;
   // dut3: READ_LAT=3, 128 words
   logic        start3 = 0, hold3 = 0, step3 = 0, rdy3 = 1;
   logic        en3, stp3, v3, ml3, busy3, done3;
   logic [6:0]  addr3, ma3;
   logic [31:0] data3 = '0, md3, p3a = '0, p3b = '0;
   // dutn: READ_LAT=2, single word
   logic        startn = 0, holdn = 0, stepn = 0, rdyn = 1;
   logic        enn, stpn, vn, mln, busyn, donen;
   logic [2:0]  addrn, man;
   logic [31:0] datan = '0, mdn, pna = '0;

   debug_scan_ctrl #(.ADDR_WIDTH(7), .NUM_WORDS(128), .READ_LAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .hold(hold1), .step_req(step1),
      .debug_en(en1), .debug_step(stp1), .debug_addr(addr1), .debug_data(data1),
      .m_valid(v1), .m_ready(rdy1), .m_data(md1), .m_addr(ma1), .m_last(ml1),
      .busy(busy1), .done(done1));

   debug_scan_ctrl #(.ADDR_WIDTH(7), .NUM_WORDS(128), .READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .hold(hold3), .step_req(step3),
      .debug_en(en3), .debug_step(stp3), .debug_addr(addr3), .debug_data(data3),
      .m_valid(v3), .m_ready(rdy3), .m_data(md3), .m_addr(ma3), .m_last(ml3),
      .busy(busy3), .done(done3));

   debug_scan_ctrl #(.ADDR_WIDTH(3), .NUM_WORDS(1), .READ_LAT(2)) dutn (
      .clk(clk), .rst(rst), .start(startn), .hold(holdn), .step_req(stepn),
      .debug_en(enn), .debug_step(stpn), .debug_addr(addrn), .debug_data(datan),
      .m_valid(vn), .m_ready(rdyn), .m_data(mdn), .m_addr(man), .m_last(mln),
      .busy(busyn), .done(donen));

   // Core stubs: data valid READ_LAT cycles after the address changes.
   always_ff @(posedge clk) begin
      data1 <= {25'h0, addr1} ^ 32'hA5A5_0000;
      p3a   <= {25'h0, addr3} ^ 32'hA5A5_0000;
      p3b   <= p3a;
      data3 <= p3b;
      pna   <= {29'h0, addrn} ^ 32'hA5A5_0000;
      datan <= pna;
   end

   function automatic logic [31:0] word_of(input int a);
      return 32'(a) ^ 32'hA5A5_0000;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Run one 128-word scan on dut1 with an optional stall word, an optional start+step poke while busy,
   // and an optional step_req issued together with start.
   task automatic scan1(input int stall_w, input int poke_w, input bit co_step);
      int  exp_w, cyc, stall_left, t_first, t_last, t_issue_last, t_done, n_done, n_step, n_stall;
      bit  en_ok;
      exp_w = 0; cyc = 0; stall_left = 10; t_first = 0; t_last = 0;
      t_issue_last = -1; t_done = -1; n_done = 0; n_step = 0; n_stall = 0; en_ok = 1;
      start1 = 1; step1 = co_step; rdy1 = 1;
      tick();
      start1 = 0; step1 = 0;
      chk("scan_start_busy", 32'(busy1), 32'd1);
      chk("scan_start_addr", 32'(addr1), 32'd0);
      while (cyc < 3000 && !(n_done > 0 && !busy1)) begin
         start1 = 0; step1 = 0; rdy1 = 1;
         if (busy1 && !en1) en_ok = 0;
         if (stp1) n_step++;
         if (done1) begin n_done++; t_done = cyc; end
         if (busy1 && addr1 == 7'd127 && t_issue_last < 0) t_issue_last = cyc;
         if (v1 && int'(ma1) == poke_w) begin start1 = 1; step1 = 1; end
         if (v1 && int'(ma1) == stall_w && stall_left > 0) begin
            rdy1 = 0; stall_left--; n_stall++;
            chk("stall_data", md1, word_of(stall_w));
            chk("stall_dbg_addr", 32'(addr1), 32'(stall_w));
         end
         if (v1 && rdy1) begin
            chk("word_data", md1, word_of(exp_w));
            chk("word_addr", 32'(ma1), 32'(exp_w));
            chk("word_last", 32'(ml1), 32'(exp_w == 127));
            if (exp_w == 0) t_first = cyc;
            t_last = cyc;
            exp_w++;
         end
         tick();
         cyc++;
      end
      start1 = 0; step1 = 0; rdy1 = 1;
      chk("scan_in_budget", 32'(cyc < 3000), 32'd1);
      for (int k = 0; k < 3; k++) begin
         if (done1) n_done++;
         if (stp1) n_step++;
         tick();
      end
      chk("scan_words", 32'(exp_w), 32'd128);
      chk("scan_done_count", 32'(n_done), 32'd1);
      chk("scan_no_step", 32'(n_step), 32'd0);
      chk("scan_en_held", 32'(en_ok), 32'd1);
      chk("scan_done_lat", 32'(t_done - t_issue_last), 32'd3);
      chk("scan_span", 32'(t_last - t_first), 32'(127 * 3 + n_stall));
      chk("scan_stall_cycles", 32'(n_stall), (stall_w >= 0) ? 32'd10 : 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nd, w3, t0, tl;

      // Reset state
      rst = 1;
      tick(); tick();
      chk("rst_en", 32'(en1), 32'd0);
      chk("rst_valid", 32'(v1), 32'd0);
      chk("rst_busy", 32'(busy1), 32'd0);
      chk("rst_addr", 32'(addr1), 32'd0);
      chk("rst_done", 32'(done1), 32'd0);
      chk("rst_step", 32'(stp1), 32'd0);
      rst = 0;
      tick();

      // Single-word scan: first word is also last
      startn = 1; tick(); startn = 0;
      tick(); tick(); tick();
      chk("one_valid", 32'(vn), 32'd1);
      chk("one_last", 32'(mln), 32'd1);
      chk("one_addr", 32'(man), 32'd0);
      chk("one_data", mdn, 32'hA5A5_0000);
      tick();
      chk("one_done", 32'(donen), 32'd1);
      chk("one_valid_clr", 32'(vn), 32'd0);
      tick();
      chk("one_done_clr", 32'(donen), 32'd0);
      chk("one_idle", 32'(busyn), 32'd0);

      // Stepping while held
      hold1 = 1; tick();
      chk("idle_en_hold", 32'(en1), 32'd1);
      for (int k = 0; k < 3; k++) begin
         step1 = 1; tick(); step1 = 0;
         chk("step_pulse", 32'(stp1), 32'd1);
         chk("step_idle", 32'(busy1), 32'd0);
         tick();
         chk("step_width", 32'(stp1), 32'd0);
         tick();
      end
      hold1 = 0; step1 = 1; tick(); step1 = 0;
      chk("step_nohold", 32'(stp1), 32'd0);
      chk("idle_en_nohold", 32'(en1), 32'd0);
      tick();

      // Full scans
      scan1(-1, -1, 1'b0);
      scan1(5, -1, 1'b0);
      hold1 = 1;
      scan1(-1, 10, 1'b0);
      scan1(-1, -1, 1'b1);
      chk("post_scan_en_hold", 32'(en1), 32'd1);
      hold1 = 0; tick();
      chk("post_scan_en_drop", 32'(en1), 32'd0);

      // Abort at word 40
      start1 = 1; tick(); start1 = 0;
      cyc = 0;
      while (cyc < 1000 && !(v1 && ma1 == 7'd40)) begin tick(); cyc++; end
      chk("abort_reach40", 32'(cyc < 1000), 32'd1);
      rst = 1; tick();
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_valid", 32'(v1), 32'd0);
      chk("abort_dbg_addr", 32'(addr1), 32'd0);
      chk("abort_done", 32'(done1), 32'd0);
      chk("abort_en", 32'(en1), 32'd0);
      rst = 0;
      nd = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done1 || busy1) nd++;
      end
      chk("abort_quiet", 32'(nd), 32'd0);
      scan1(-1, -1, 1'b0);

      // READ_LAT=3 scan
      start3 = 1; tick(); start3 = 0;
      cyc = 0; nd = 0; w3 = 0; t0 = 0; tl = 0;
      while (cyc < 3000 && !(nd > 0 && !busy3)) begin
         if (done3) nd++;
         if (v3) begin
            chk("lat3_data", md3, word_of(w3));
            chk("lat3_addr", 32'(ma3), 32'(w3));
            if (w3 == 0) t0 = cyc;
            tl = cyc;
            w3++;
         end
         tick();
         cyc++;
      end
      chk("lat3_words", 32'(w3), 32'd128);
      chk("lat3_done_count", 32'(nd), 32'd1);
      chk("lat3_period", 32'(tl - t0), 32'(127 * 5));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/debug_scan_ctrl.md
Name: debug_scan_ctrl

Overview:
- Initiator side of the RV32core debug port (debug_en / debug_step / debug_addr / debug_data).
- On a start pulse it halts the core and walks debug_addr over 0..NUM_WORDS-1, capturing debug_data after a fixed read latency.
- Each captured word is streamed out on a valid/ready interface toward a UART/VGA dumper.
- Also issues single-cycle step pulses while the core is held, so software-free bring-up can single-step the Tomasulo core and dump register, RS and memory state after every cycle.

Parameters:
- ADDR_WIDTH, 7, width of debug_addr.
- NUM_WORDS, 128, number of debug addresses scanned per snapshot (1..2^ADDR_WIDTH).
- READ_LAT, 1, cycles from debug_addr change to valid debug_data (1..4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin snapshot scan
- hold  in  1  keep core halted (debug_en high) while idle
- step_req  in  1  pulse: advance core one cycle
- debug_en  out  1  core halt/debug enable
- debug_step  out  1  single-cycle core step strobe
- debug_addr  out  ADDR_WIDTH  debug read address
- debug_data  in  32  debug read data from core
- m_valid  out  1  stream word valid
- m_ready  in  1  stream sink ready
- m_data  out  32  captured word
- m_addr  out  ADDR_WIDTH  address the word came from
- m_last  out  1  final word of snapshot
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; address counter 0; wait counter 0. Applies mid-scan too: the scan is aborted with no done pulse, and debug_en drops to 0 next cycle unless hold=1 after reset release.
- States:
  - IDLE: busy=0. debug_en=hold. On start, go to ISSUE with addr=0. Otherwise, if step_req=1 and hold=1, pulse debug_step for exactly one cycle.
  - ISSUE: debug_en=1, debug_addr=addr, wait counter loaded with READ_LAT-1. Go to WAIT.
  - WAIT: decrement until 0, then register debug_data into m_data and addr into m_addr. Go to SEND.
  - SEND: m_valid=1; m_data, m_addr and m_last stay stable while m_ready=0 (no timeout). A transfer occurs when m_valid&&m_ready. m_last = (addr==NUM_WORDS-1). After transfer: if last, go to FIN; else addr+1 and go to ISSUE.
  - FIN: done=1 for one cycle, then IDLE.
- Per-word latency = 1 (ISSUE) + READ_LAT (WAIT) + ≥1 (SEND); 3 cycles with READ_LAT=1 and m_ready tied high.
- busy=1 in ISSUE, WAIT, SEND and FIN.
- debug_en=1 continuously from the cycle after start until FIN inclusive, so the snapshot is coherent.
- debug_step is never asserted outside IDLE. step_req outside IDLE is dropped, not queued.
- start while busy is ignored. start and step_req together in IDLE: start wins and no step is issued.
- debug_addr is held at the last issued address outside ISSUE/WAIT, and returns to 0 on reset.
- The address counter never wraps: the scan stops at NUM_WORDS-1. With NUM_WORDS=1, the first word carries m_last=1.
- Counter widths: addr ADDR_WIDTH bits; wait counter clog2(READ_LAT)+1 bits.

Decomposition:
- Shared package: state encoding (IDLE, ISSUE, WAIT, SEND, FIN as 3-bit localparams), DEBUG_DATA_W=32, and the debug address-map constants used by the dumper: register file 0..31, RS/RRS window, data-memory window.
- Natural sub-module: debug_out_reg. It is a one-entry valid/ready output holding register (data, addr, last) with load/accept handshake, so it can later be swapped for a 2-entry skid buffer.

Test Plan:
- Full scan, READ_LAT=1, m_ready=1, core stub returns debug_data = {25'h0, addr} ^ 32'hA5A5_0000 -> 128 words in order, m_addr 0..127, m_last only at 127, done exactly 3 cycles after word 127 is issued, debug_en high throughout the scan.
- Backpressure: m_ready low for 10 cycles on word 5 -> m_valid stays high, m_data=32'hA5A5_0005 stable, debug_addr stays 5, no skip or duplicate.
- READ_LAT=3 with the stub delaying data 3 cycles -> every word matches its address; per-word period is 5 cycles with m_ready=1.
- Step: hold=1, three step_req pulses in IDLE -> exactly three one-cycle debug_step pulses. step_req during a scan -> no pulse. start and step_req in the same cycle -> scan starts, no step.
- Reset mid-scan at word 40 -> next cycle busy=0, m_valid=0, debug_addr=0, no done. A new start afterwards scans from 0.
- start asserted again while busy at word 10 -> ignored; the scan completes with a single done pulse.
